// File: rtl/move_executor.sv
// Responder for the move handshake: decodes a 4-bit move code, steps one face driver,
// waits for the mechanics to settle and pulses move_done. Define STEP_RAMP_EN for half-speed end ramps.
module move_executor #(
    parameter int STEPS_PER_QUARTER = 50,
    parameter int HALF_PERIOD       = 50000,
    parameter int DIR_SETUP         = 100,
    parameter int SETTLE_CYCLES     = 100000,
    parameter int RAMP_STEPS        = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_move,
    input  logic [3:0] next_move,
    output logic       move_done,
    output logic       busy,
    output logic [3:0] current_move,
    output logic [5:0] step_out,
    output logic [5:0] dir_out,
    output logic [5:0] motor_en
);

    localparam int MAX_A   = (DIR_SETUP > 2 * HALF_PERIOD) ? DIR_SETUP : 2 * HALF_PERIOD;
    localparam int MAX_CNT = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int PW      = $clog2(STEPS_PER_QUARTER + 1);

    localparam logic [CW-1:0] SETUP_LAST  = CW'(DIR_SETUP - 1);
    localparam logic [CW-1:0] HALF_LAST   = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST  = PW'(STEPS_PER_QUARTER - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_NOOP    = 3'd1,
        S_SETUP   = 3'd2,
        S_STEP_HI = 3'd3,
        S_STEP_LO = 3'd4,
        S_SETTLE  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_pulse;
    logic [2:0]    r_face;
    logic          r_move_done;
    logic          r_busy;
    logic [3:0]    r_current_move;
    logic [5:0]    r_step;
    logic [5:0]    r_dir;
    logic [5:0]    r_motor_en;

    logic          w_code_valid;
    logic [2:0]    w_face;
    logic          w_cw;
    logic          w_slow;
    logic [CW-1:0] w_phase_last;

    // Decode the requested code and pick the length of the current step phase
    always_comb begin
        w_code_valid = (next_move >= 4'd1) && (next_move <= 4'd12);
        w_cw         = (next_move <= 4'd6);
        if (w_cw) begin
            w_face = 3'(next_move - 4'd1);
        end else begin
            w_face = 3'(next_move - 4'd7);
        end
`ifdef STEP_RAMP_EN
        if (2 * RAMP_STEPS >= STEPS_PER_QUARTER) begin
            w_slow = 1'b1;
        end else begin
            w_slow = (r_pulse < PW'(RAMP_STEPS)) ||
                     (r_pulse >= PW'(STEPS_PER_QUARTER - RAMP_STEPS));
        end
        if (w_slow) begin
            w_phase_last = CW'(2 * HALF_PERIOD - 1);
        end else begin
            w_phase_last = HALF_LAST;
        end
`else
        w_slow       = 1'b0;
        w_phase_last = HALF_LAST;
`endif
    end

    // Move FSM; every output is a register derived from the state it leaves
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_pulse        <= '0;
            r_face         <= 3'd0;
            r_move_done    <= 1'b0;
            r_busy         <= 1'b0;
            r_current_move <= 4'd0;
            r_step         <= 6'd0;
            r_dir          <= 6'd0;
            r_motor_en     <= 6'd0;
        end else begin
            r_move_done <= (r_state == S_DONE);
            r_busy      <= (r_state != S_IDLE);
            r_step      <= (r_state == S_STEP_HI) ? (6'b000001 << r_face) : 6'd0;
            case (r_state)
                S_IDLE: begin
                    if (start_move) begin
                        r_current_move <= next_move;
                        r_cnt          <= '0;
                        r_pulse        <= '0;
                        if (w_code_valid) begin
                            r_face             <= w_face;
                            r_dir[w_face]      <= w_cw;
                            r_motor_en[w_face] <= 1'b1;
                            r_state            <= S_SETUP;
                        end else begin
                            r_state <= S_NOOP;
                        end
                    end
                end
                S_NOOP: r_state <= S_DONE;
                S_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_STEP_HI;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STEP_HI: begin
                    if (r_cnt == w_phase_last) begin
                        r_cnt   <= '0;
                        r_state <= S_STEP_LO;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STEP_LO: begin
                    if (r_cnt == w_phase_last) begin
                        r_cnt <= '0;
                        if (r_pulse == PULSE_LAST) begin
                            r_pulse <= '0;
                            r_state <= S_SETTLE;
                        end else begin
                            r_pulse <= r_pulse + PW'(1);
                            r_state <= S_STEP_HI;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign move_done    = r_move_done;
    assign busy         = r_busy;
    assign current_move = r_current_move;
    assign step_out     = r_step;
    assign dir_out      = r_dir;
    assign motor_en     = r_motor_en;

endmodule
